// File: rtl/ram_select_sequencer_if.sv
// Bus bundle for ram_select_sequencer: request capture inputs, beat gating inputs
// and the row-select / status outputs.
interface ram_select_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
);
  logic                   start;
  logic [ADDR_W-1:0]      adress;
  logic [LEN_W-1:0]       burst_len;
  logic [1:0]             mode;
  logic                   enram;
  logic                   stall;
  logic [2**ADDR_W-1:0]   selectList;
  logic [ADDR_W-1:0]      cur_addr;
  logic                   beat_valid;
  logic                   busy;
  logic                   done;

  modport master (
    output start, adress, burst_len, mode, enram, stall,
    input  selectList, cur_addr, beat_valid, busy, done
  );

  modport slave (
    input  start, adress, burst_len, mode, enram, stall,
    output selectList, cur_addr, beat_valid, busy, done
  );
endinterface

// File: rtl/ram_select_sequencer.sv
// Walks a one-hot RAM row select over a single, incrementing or decrementing
// burst; enram gates the row select and, with stall, holds the current beat.
module ram_select_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_select_sequencer_if.slave bus
);
  localparam int ROWS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [1:0]        mode_q;
  logic [ROWS-1:0]   sel_q;
  logic              busy_q;
  logic              done_q;

  logic              advance_d;
  logic [ADDR_W-1:0] addr_d;

  function automatic logic [ROWS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [ROWS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Advance qualifier and the address of the following beat (modulo 2**ADDR_W).
  always_comb begin
    advance_d = (state_q == ACTIVE) && bus.enram && !bus.stall;
    case (mode_q)
      2'b01:   addr_d = addr_q + ADDR_ONE;
      2'b10:   addr_d = addr_q - ADDR_ONE;
      default: addr_d = addr_q;
    endcase
  end

  // Sequencer FSM; sel_q tracks one-hot(cur_addr) only while a beat is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q  <= bus.adress;
            mode_q  <= bus.mode;
            cnt_q   <= (bus.mode == 2'b01 || bus.mode == 2'b10) ? bus.burst_len : '0;
            sel_q   <= onehot(bus.adress);
            busy_q  <= 1'b1;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (advance_d) begin
            if (cnt_q == '0) begin
              sel_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q <= addr_d;
              sel_q  <= onehot(addr_d);
              cnt_q  <= cnt_q - CNT_ONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          sel_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.selectList = bus.enram ? sel_q : '0;
  assign bus.beat_valid = advance_d;
  assign bus.cur_addr   = addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_ram_select_sequencer.sv
// Scoreboard bench: stimulus pushes the expected beat-address sequence per burst,
// negedge monitors pop and compare whatever the two DUT instances present.
module tb_ram_select_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_select_sequencer_if #(.ADDR_W(8), .LEN_W(4)) ifa ();
  ram_select_sequencer_if #(.ADDR_W(4), .LEN_W(2)) ifb ();

  ram_select_sequencer #(.ADDR_W(8), .LEN_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ram_select_sequencer #(.ADDR_W(4), .LEN_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int qa[$];   // expected beat addresses, -1 marks the done pulse
  int qb[$];

  task automatic fail_msg(input string name, input logic [255:0] got, input logic [255:0] exp);
    failures++;
    $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin : mon_a
    int h;
    logic [255:0] e;
    if (mon_en) begin
      checks++;
      if ($countones(ifa.selectList) > 1 || (ifa.done && ifa.beat_valid) ||
          (!ifa.busy && (ifa.beat_valid || ifa.done || ifa.selectList != '0)))
        fail_msg("A_invariant", {ifa.busy, ifa.done, ifa.beat_valid}, 256'd0);
      if (ifa.busy && !ifa.done) begin
        checks++;
        if (qa.size() == 0 || qa[0] < 0) begin
          fail_msg("A_active_unexpected", ifa.cur_addr, 256'd0);
        end else begin
          h = qa[0];
          e = '0;
          if (ifa.enram) e[h[7:0]] = 1'b1;
          if (ifa.cur_addr != h[7:0] || ifa.selectList != e ||
              ifa.beat_valid != (ifa.enram && !ifa.stall))
            fail_msg("A_beat", {ifa.beat_valid, ifa.cur_addr, ifa.selectList}, {ifa.enram && !ifa.stall, h[7:0], e});
          if (ifa.beat_valid) void'(qa.pop_front());
        end
      end
      if (ifa.done) begin
        checks++;
        if (qa.size() == 0 || qa[0] >= 0) fail_msg("A_done_early", qa.size(), 256'd0);
        else void'(qa.pop_front());
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin : mon_b
    int h;
    logic [15:0] e;
    if (mon_en) begin
      checks++;
      if ($countones(ifb.selectList) > 1 || (ifb.done && ifb.beat_valid) ||
          (!ifb.busy && (ifb.beat_valid || ifb.done || ifb.selectList != '0)))
        fail_msg("B_invariant", {ifb.busy, ifb.done, ifb.beat_valid}, 256'd0);
      if (ifb.busy && !ifb.done) begin
        checks++;
        if (qb.size() == 0 || qb[0] < 0) begin
          fail_msg("B_active_unexpected", ifb.cur_addr, 256'd0);
        end else begin
          h = qb[0];
          e = '0;
          if (ifb.enram) e[h[3:0]] = 1'b1;
          if (ifb.cur_addr != h[3:0] || ifb.selectList != e ||
              ifb.beat_valid != (ifb.enram && !ifb.stall))
            fail_msg("B_beat", {ifb.beat_valid, ifb.cur_addr, ifb.selectList}, {ifb.enram && !ifb.stall, h[3:0], e});
          if (ifb.beat_valid) void'(qb.pop_front());
        end
      end
      if (ifb.done) begin
        checks++;
        if (qb.size() == 0 || qb[0] >= 0) fail_msg("B_done_early", qb.size(), 256'd0);
        else void'(qb.pop_front());
      end
    end
  end

  // One burst on instance A; stall_at/off_at use cycle 1 = first beat cycle, 0 = none.
  task automatic run_a(input int addr, input int len, input int mode,
                       input int stall_at, input int off_at, input int off_len, input bit rnd);
    int nb, dir, adv, cyc;
    bit en, st;
    nb  = (mode == 1 || mode == 2) ? len + 1 : 1;
    dir = (mode == 2) ? -1 : 1;
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.adress = addr[7:0]; ifa.burst_len = len[3:0];
    ifa.mode = mode[1:0]; ifa.enram = 1'b1; ifa.stall = 1'b0;
    for (int i = 0; i < nb; i++) qa.push_back((addr + dir * i) & 255);
    qa.push_back(-1);
    @(posedge clk); #1;
    ifa.start = 1'b0;
    adv = 0;
    cyc = 1;
    while (adv < nb && cyc < 300) begin
      en = !(cyc >= off_at && cyc < off_at + off_len);
      st = (cyc == stall_at);
      if (rnd) begin
        en = en && ($urandom_range(3) != 0);
        st = st || ($urandom_range(3) == 0);
        ifa.start  = 1'($urandom_range(1));
        ifa.adress = 8'($urandom);
      end
      ifa.enram = en;
      ifa.stall = st;
      if (en && !st) adv++;
      @(posedge clk); #1;
      cyc++;
    end
    ifa.start = rnd ? 1'($urandom_range(1)) : 1'b0;
    ifa.enram = 1'b1;
    ifa.stall = 1'b0;
    @(negedge clk);
    checks++;
    if (!ifa.done || ifa.beat_valid || ifa.selectList != '0)
      fail_msg("A_done_cycle", {ifa.done, ifa.beat_valid, ifa.selectList}, {1'b1, 1'b0, 256'd0});
    @(posedge clk); #1;
    ifa.start = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.busy || ifa.done || ifa.beat_valid)
      fail_msg("A_idle_after_done", {ifa.busy, ifa.done, ifa.beat_valid}, 256'd0);
  endtask

  // One burst on instance B with optional random enram/stall gating.
  task automatic run_b(input int addr, input int len, input int mode, input bit rnd);
    int nb, dir, adv, cyc;
    bit en, st;
    nb  = (mode == 1 || mode == 2) ? len + 1 : 1;
    dir = (mode == 2) ? -1 : 1;
    @(posedge clk); #1;
    ifb.start = 1'b1; ifb.adress = addr[3:0]; ifb.burst_len = len[1:0];
    ifb.mode = mode[1:0]; ifb.enram = 1'b1; ifb.stall = 1'b0;
    for (int i = 0; i < nb; i++) qb.push_back((addr + dir * i) & 15);
    qb.push_back(-1);
    @(posedge clk); #1;
    ifb.start = 1'b0;
    adv = 0;
    cyc = 1;
    while (adv < nb && cyc < 300) begin
      en = rnd ? ($urandom_range(3) != 0) : 1'b1;
      st = rnd ? ($urandom_range(3) == 0) : 1'b0;
      ifb.enram = en;
      ifb.stall = st;
      if (en && !st) adv++;
      @(posedge clk); #1;
      cyc++;
    end
    ifb.enram = 1'b1;
    ifb.stall = 1'b0;
    @(negedge clk);
    checks++;
    if (!ifb.done || ifb.beat_valid)
      fail_msg("B_done_cycle", {ifb.done, ifb.beat_valid}, {1'b1, 1'b0});
  endtask

  initial begin
    ifa.start = 1'b0; ifa.adress = '0; ifa.burst_len = '0; ifa.mode = 2'b00;
    ifa.enram = 1'b1; ifa.stall = 1'b0;
    ifb.start = 1'b0; ifb.adress = '0; ifb.burst_len = '0; ifb.mode = 2'b00;
    ifb.enram = 1'b1; ifb.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifa.selectList != '0 || ifa.cur_addr != 8'h00 || ifa.beat_valid || ifa.busy || ifa.done)
      fail_msg("A_reset", {ifa.cur_addr, ifa.beat_valid, ifa.busy, ifa.done}, 256'd0);
    checks++;
    if (ifb.selectList != '0 || ifb.cur_addr != 4'h0 || ifb.beat_valid || ifb.busy || ifb.done)
      fail_msg("B_reset", {ifb.cur_addr, ifb.beat_valid, ifb.busy, ifb.done}, 256'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_a(8'h05, 7, 0, 0, 0, 0, 1'b0);
    run_a(8'hFE, 3, 1, 0, 0, 0, 1'b0);
    run_a(8'h01, 2, 2, 2, 0, 0, 1'b0);
    run_a(8'h10, 3, 1, 0, 2, 2, 1'b0);
    run_a(8'h80, 5, 3, 0, 0, 0, 1'b0);
    run_b(4'hE, 3, 1, 1'b0);

    // Mid-burst reset with ignored starts in ACTIVE and start held across the reset edge.
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.adress = 8'h40; ifa.burst_len = 4'hF; ifa.mode = 2'b01;
    for (int i = 0; i < 16; i++) qa.push_back(8'h40 + i);
    qa.push_back(-1);
    @(posedge clk); #1;
    ifa.adress = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    qa.delete();
    qb.delete();
    rst_n = 1'b1;
    ifa.start = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.selectList != '0 || ifa.cur_addr != 8'h00 || ifa.beat_valid || ifa.busy || ifa.done)
      fail_msg("A_mid_reset", {ifa.cur_addr, ifa.beat_valid, ifa.busy, ifa.done}, 256'd0);
    repeat (4) @(negedge clk);
    run_a(8'h22, 1, 2, 0, 0, 0, 1'b0);

    for (int n = 0; n < 30; n++)
      run_a(int'($urandom_range(255)), int'($urandom_range(15)), int'($urandom_range(3)), 0, 0, 0, 1'b1);
    for (int n = 0; n < 12; n++)
      run_b(int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(3)), 1'b1);

    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0)
      fail_msg("scoreboard_drain", {qa.size(), qb.size()}, 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_select_sequencer.md
RAM_SELECT_SEQUENCER -- requirements
Module: ram_select_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, address width; selectList width is 2**ADDR_W.
REQ-002 Parameter LEN_W, default 4, burst-length field width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a new access sequence; sampled only in IDLE.
REQ-006 adress  input  ADDR_W  start address, captured with start.
REQ-007 burst_len  input  LEN_W  beats minus one, captured with start; 0 means a single beat.
REQ-008 mode  input  2  captured with start: 00 single, 01 incrementing burst, 10 decrementing burst, 11 reserved.
REQ-009 enram  input  1  RAM enable; when 0, selectList is forced to zero and the sequence holds.
REQ-010 stall  input  1  when 1, the sequence holds its current beat.
REQ-011 selectList  output  2**ADDR_W  registered one-hot row select; bit k is set for address k.
REQ-012 cur_addr  output  ADDR_W  registered address of the current beat.
REQ-013 beat_valid  output  1  high when selectList carries an active beat.
REQ-014 busy  output  1  high in ACTIVE and DONE.
REQ-015 done  output  1  one-cycle pulse on sequence completion.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACTIVE and DONE.
REQ-017 IDLE with start=1: capture adress, burst_len and mode, load the beat counter, and go to ACTIVE.
- Start seen at edge T drives the first beat at T+1, so latency is 1 cycle.
REQ-018 ACTIVE, advance condition (enram=1 and stall=0):
- beat_valid=1 and selectList = one-hot(cur_addr).
- At the edge, cur_addr steps by +1 (mode 01) or -1 (mode 10) and the counter decrements.
REQ-019 ACTIVE with enram=0 or stall=1: cur_addr and the counter hold.
- beat_valid=0.
- selectList = 0 when enram=0; selectList = one-hot(cur_addr) when enram=1 and stall=1.
REQ-020 Address arithmetic SHALL be modulo 2**ADDR_W, so 255+1 -> 0 and 0-1 -> 255 at ADDR_W=8.
REQ-021 A beat counter of 0 at an advance edge ends the burst.
- Next state is DONE and cur_addr does not step.
- Total valid beats = burst_len+1.
REQ-022 Mode 00 and mode 11 SHALL perform exactly one beat regardless of burst_len.
REQ-023 DONE lasts exactly one cycle.
- done=1, beat_valid=0, selectList=0.
- Then IDLE, unconditionally.
REQ-024 start SHALL be ignored in ACTIVE and DONE, with no queuing.
- A new start is accepted earliest in the first IDLE cycle after DONE.
REQ-025 In IDLE: selectList=0, beat_valid=0, busy=0, done=0, and cur_addr holds its last value.
REQ-026 At most one selectList bit SHALL be high in any cycle.
REQ-027 done and beat_valid SHALL never be high in the same cycle.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL enter IDLE with all of the following cleared:
- selectList=0, cur_addr=0, beat_valid=0, busy=0, done=0.
- Beat counter and captured mode cleared.
REQ-029 Reset mid-sequence SHALL abort the sequence without a done pulse.
- rst_n has priority over start, stall and enram.
REQ-030 With rst_n=0 and no clock edge, outputs SHALL keep their values.

Verification
REQ-031 Single beat: start, adress=0x05, mode=00, burst_len=7.
- One cycle later: selectList[5]=1 and beat_valid=1 for 1 cycle.
- Next cycle: done=1.
- Cycle after that: IDLE.
REQ-032 Incrementing wrap: adress=0xFE, mode=01, burst_len=3.
- Beats at addresses FE, FF, 00, 01.
- done pulses on the 5th cycle after start.
REQ-033 Decrementing burst with stall: adress=0x01, mode=10, burst_len=2, stall=1 for the 2nd beat cycle only.
- Addresses 01, 00 (held 2 cycles, beat_valid=0 during the stall), FF.
- Exactly 3 beat_valid pulses.
REQ-034 enram gating: enram=0 during a 4-beat incrementing burst from 0x10, for 2 cycles after the first beat.
- selectList=0 during the gap.
- Beats at 10, 11, 12, 13, each valid once.
REQ-035 Reset and ignored start:
- start pulsed again in ACTIVE -> no effect.
- rst_n=0 mid-burst -> next cycle all outputs 0 and no done pulse.
- After rst_n=1, a new start is accepted.
REQ-036 Parameter sweep: ADDR_W=4, LEN_W=2.
- Incrementing burst from 0xE with burst_len=3 gives addresses E, F, 0, 1 on a 16-bit selectList.
- One-hot holds every cycle.
